// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: drives the PLL reset, qualifies its async lock, holds system reset until stable.
// Latency: lock loss reaches RESET_PLL 3 edges after pll_locked falls; restart acts at the sampling edge.
// Backpressure: none; free-running on the reference clock, outputs decoded from registered state.
//
// Ports:
//   i_clk          reference clock (never a PLL output)
//   i_rst_n        asynchronous active-low reset
//   i_pll_locked   PLL lock indication, asynchronous to i_clk
//   i_restart      synchronous request to re-sequence the PLL
//   o_pll_rst      active-high reset request to the PLL (state RESET_PLL)
//   o_sys_reset    active-high downstream reset (any state but RUN)
//   o_ready        high only in RUN
//   o_state        0 RESET_PLL, 1 WAIT_LOCK, 2 HOLD, 3 RUN
//   o_loss_count   lock-loss events, saturating at 255
//   o_retry_count  WAIT_LOCK timeouts, saturating at 255
module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int HOLD_CYCLES    = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  input  logic       i_restart,
  output logic       o_pll_rst,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic [1:0] o_state,
  output logic [7:0] o_loss_count,
  output logic [7:0] o_retry_count
);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // One shared phase counter covers the reset, stability and hold phases.
  localparam int CMAX = (RST_CYCLES > STABLE_CYCLES) ?
                        ((RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES) :
                        ((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES);
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tcnt;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_loss_count;
  logic [7:0]  r_retry_count;

  logic w_locked_s;
  logic w_timeout;

  assign w_locked_s = r_sync2;
  assign w_timeout  = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_RESET_PLL;
      r_cnt         <= '0;
      r_tcnt        <= '0;
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_loss_count  <= 8'd0;
      r_retry_count <= 8'd0;
    end else begin
      r_sync1 <= i_pll_locked;
      r_sync2 <= r_sync1;

      case (r_state)
        S_RESET_PLL: begin
          // restart simply re-arms the full reset pulse width
          if (i_restart) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(RST_CYCLES - 1)) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_tcnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (i_restart) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
          end else begin
            // timeout runs independently of lock glitches
            r_tcnt <= r_tcnt + TW'(1);
            if (w_locked_s && (r_cnt == CW'(STABLE_CYCLES - 1))) begin
              // accepting lock wins over a coincident timeout
              r_state <= S_HOLD;
              r_cnt   <= '0;
            end else if (w_timeout) begin
              r_state <= S_RESET_PLL;
              r_cnt   <= '0;
              if (r_retry_count != 8'hFF) r_retry_count <= r_retry_count + 8'd1;
            end else if (w_locked_s) begin
              r_cnt <= r_cnt + CW'(1);
            end else begin
              r_cnt <= '0;
            end
          end
        end

        S_HOLD, S_RUN: begin
          // loss of lock outranks restart so the event is always counted
          if (!w_locked_s) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
            if (r_loss_count != 8'hFF) r_loss_count <= r_loss_count + 8'd1;
          end else if (i_restart) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
          end else if (r_state == S_HOLD) begin
            if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        default: begin
          r_state <= S_RESET_PLL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_state       = r_state;
  assign o_pll_rst     = (r_state == S_RESET_PLL);
  assign o_sys_reset   = (r_state != S_RUN);
  assign o_ready       = (r_state == S_RUN);
  assign o_loss_count  = r_loss_count;
  assign o_retry_count = r_retry_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;
  localparam int RST     = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 16;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_pll_locked;
  logic       i_restart;
  logic       o_pll_rst;
  logic       o_sys_reset;
  logic       o_ready;
  logic [1:0] o_state;
  logic [7:0] o_loss_count;
  logic [7:0] o_retry_count;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST),
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_pll_locked (i_pll_locked),
    .i_restart    (i_restart),
    .o_pll_rst    (o_pll_rst),
    .o_sys_reset  (o_sys_reset),
    .o_ready      (o_ready),
    .o_state      (o_state),
    .o_loss_count (o_loss_count),
    .o_retry_count(o_retry_count)
  );

  // Expected state-change event: the edge it happens at and the visible result.
  typedef struct {
    int edge_n;
    int st;
    int loss;
    int retry;
  } ev_t;

  ev_t exp_q[$];
  bit  lk_q[$];   // pll_locked value sampled at edge n (index 0 unused)
  bit  rs_q[$];   // restart value sampled at edge n
  int  n_edges;
  int  edge_no = 0;
  bit  mon_en  = 1'b0;
  int  total   = 0;
  int  bad     = 0;
  int  m_loss  = 0;
  int  m_retry = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, want, edge_no);
    end
  endtask

  task automatic add(bit l, bit r, int count);
    for (int k = 0; k < count; k++) begin
      lk_q.push_back(l);
      rs_q.push_back(r);
    end
  endtask

  // Synchronized lock as seen by the decision at edge e: input from two edges earlier.
  function automatic bit ls(int e);
    return (e >= 3) ? lk_q[e-2] : 1'b0;
  endfunction

  // Phase-duration model: each phase lasts a fixed number of qualifying edges
  // or ends on the first event that preempts it.
  task automatic build_model();
    int ph   = 0;
    int t    = 0;   // edge at which the current phase was entered
    int mark = 0;   // last edge that (re)started the reset pulse
    int run  = 0;   // consecutive locked edges in the wait phase
    int nxt;
    for (int e = 1; e <= n_edges; e++) begin
      nxt = ph;
      case (ph)
        0: if (rs_q[e]) mark = e;
           else if (e - mark == RST) nxt = 1;
        1: if (rs_q[e]) nxt = 0;
           else begin
             run = ls(e) ? run + 1 : 0;
             if (run == STABLE) nxt = 2;
             else if (e - t == TIMEOUT) begin
               nxt = 0;
               if (m_retry < 255) m_retry++;
             end
           end
        default: begin
          if (!ls(e)) begin
            nxt = 0;
            if (m_loss < 255) m_loss++;
          end else if (rs_q[e]) nxt = 0;
          else if (ph == 2 && e - t == HOLD) nxt = 3;
        end
      endcase
      if (nxt != ph) begin
        exp_q.push_back('{edge_n: e, st: nxt, loss: m_loss, retry: m_retry});
        ph   = nxt;
        t    = e;
        mark = e;
        run  = 0;
      end
    end
  endtask

  // Monitor: every visible state change is matched against the next expected event.
  int prev_st = 0;
  always @(negedge clk) begin
    if (mon_en && (int'(o_state) != prev_st)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got state %0d at edge %0d expected none", o_state, edge_no);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        chk("event_edge",  edge_no,       ev.edge_n);
        chk("event_state", o_state,       ev.st);
        chk("loss_count",  o_loss_count,  ev.loss);
        chk("retry_count", o_retry_count, ev.retry);
        chk("pll_rst",     o_pll_rst,     (ev.st == 0) ? 1 : 0);
        chk("sys_reset",   o_sys_reset,   (ev.st != 3) ? 1 : 0);
        chk("ready",       o_ready,       (ev.st == 3) ? 1 : 0);
      end
      prev_st = int'(o_state);
    end
  end

  initial begin
    int v;
    int len;
    // Directed prologue (edge indices in comments).
    lk_q.push_back(1'b0); rs_q.push_back(1'b0);
    add(1, 0, 39);      // 1..39   lock held: RUN at edge 28
    add(0, 0, 1);       // 40      one-cycle lock drop: loss at edge 42
    add(1, 0, 39);      // 41..79  full re-lock
    add(1, 1, 1);       // 80      restart in RUN
    add(1, 0, 2);       // 81..82
    add(1, 1, 1);       // 83      restart in RESET_PLL at cnt=2
    add(1, 0, 8);       // 84..91  wait phase gets 6 locked edges
    add(0, 0, 1);       // 92      glitch
    add(1, 0, 57);      // 93..149 steady lock, HOLD after 8 more
    add(0, 0, 20550);   // no lock: 300+ timeouts, retry saturates
    while (lk_q.size() < 25700) begin
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      len = (v != 0) ? $urandom_range(1, 120) : $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        lk_q.push_back(v[0]);
        rs_q.push_back($urandom_range(0, 199) == 0);
      end
    end
    n_edges = lk_q.size() - 1;
    build_model();

    i_rst_n      = 1'b0;
    i_pll_locked = lk_q[1];
    i_restart    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",       o_state,       0);
    chk("rst_pll_rst",     o_pll_rst,     1);
    chk("rst_sys_reset",   o_sys_reset,   1);
    chk("rst_ready",       o_ready,       0);
    chk("rst_loss_count",  o_loss_count,  0);
    chk("rst_retry_count", o_retry_count, 0);

    @(negedge clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    for (int n = 1; n <= n_edges; n++) begin
      i_pll_locked = lk_q[n];
      i_restart    = rs_q[n];
      @(posedge clk);
      edge_no = n;
      @(negedge clk);
    end
    mon_en = 1'b0;
    chk("events_missing", exp_q.size(), 0);
    chk("final_loss",  o_loss_count,  m_loss);
    chk("final_retry", o_retry_count, m_retry);
    chk("retry_saturated", o_retry_count, 255);

    // Bring the block into HOLD, then reset it asynchronously between edges.
    i_pll_locked = 1'b1;
    i_restart    = 1'b1;
    @(negedge clk);
    i_restart = 1'b0;
    for (int k = 0; k < 200 && o_state != 2'd2; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("mid_hold", o_state, 2);
    @(posedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_state",     o_state,       0);
    chk("async_pll_rst",   o_pll_rst,     1);
    chk("async_sys_reset", o_sys_reset,   1);
    chk("async_ready",     o_ready,       0);
    chk("async_loss",      o_loss_count,  0);
    chk("async_retry",     o_retry_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
